// File: rtl/nibble_add_arbiter_pkg.sv
// Shared definitions for the nibble adder arbiter: controller state encoding
// and datapath widths.
package nibble_add_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int NIB_W  = 4;
   localparam int SUM_W  = 5;
   localparam int FULL_W = 9;

endpackage

// File: rtl/nibble_add_arbiter_add_unit.sv
// Shared nibble adder: adds either the lower (ctrl=0) or upper (ctrl=1)
// nibbles of two bytes, keeping the carry in the 5-bit result.
module nibble_add_unit
   import nibble_add_arbiter_pkg::*;
(
   input  logic [7:0]       a,
   input  logic [7:0]       b,
   input  logic             ctrl,
   output logic [SUM_W-1:0] q
);

   logic [NIB_W-1:0] nib_a;
   logic [NIB_W-1:0] nib_b;

   always_comb begin
      nib_a = ctrl ? a[7:4] : a[3:0];
      nib_b = ctrl ? b[7:4] : b[3:0];
      q     = {1'b0, nib_a} + {1'b0, nib_b};
   end

endmodule

// File: rtl/nibble_add_arbiter.sv
// Two-requester front end that time-shares one nibble adder: arbitrates,
// sums low then high nibble, and returns the tagged result on a valid/ready port.
module nibble_add_arbiter
   import nibble_add_arbiter_pkg::*;
#(
   parameter bit RR_EN = 1'b1,
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [7:0]        req0_a,
   input  logic [7:0]        req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [7:0]        req1_a,
   input  logic [7:0]        req1_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [SUM_W-1:0]  rsp_lo,
   output logic [SUM_W-1:0]  rsp_hi,
   output logic [FULL_W-1:0] rsp_full,
   output logic              busy,
   output logic [CNT_W-1:0]  op_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state;
   state_t           state_next;
   logic             last_grant;
   logic             grant;
   logic             accept;
   logic [7:0]       op_a;
   logic [7:0]       op_b;
   logic [SUM_W-1:0] sum;

   nibble_add_unit u_add (
      .a    (op_a),
      .b    (op_b),
      .ctrl (state == HI),
      .q    (sum)
   );

   // The grant only matters when a requester is valid; readies are held low in reset.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         grant = RR_EN ? ~last_grant : 1'b0;
      end else if (req1_valid) begin
         grant = 1'b1;
      end
      req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
      req1_ready = rst_n && (state == IDLE) && req1_valid && grant;
      accept     = req0_ready || req1_ready;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (accept) state_next = LO;
         LO:   state_next = HI;
         HI:   state_next = DONE;
         DONE: if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy      = (state != IDLE);
   assign rsp_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         op_a       <= '0;
         op_b       <= '0;
         rsp_id     <= 1'b0;
         rsp_lo     <= '0;
         rsp_hi     <= '0;
         rsp_full   <= '0;
         op_count   <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            op_a       <= grant ? req1_a : req0_a;
            op_b       <= grant ? req1_b : req0_b;
            rsp_id     <= grant;
            last_grant <= grant;
         end
         if (state == LO) begin
            rsp_lo <= sum;
         end
         // The high nibble sum carries weight 16 relative to the low one.
         if (state == HI) begin
            rsp_hi   <= sum;
            rsp_full <= {sum, 4'b0000} + {4'b0000, rsp_lo};
         end
         if ((state == DONE) && rsp_ready && (op_count != CNT_MAX)) begin
            op_count <= op_count + CNT_ONE;
         end
      end
   end

endmodule
